// File: rtl/keypad_mallet_scanner_if.sv
// Mallet/keypad bundle between the keypad scanner and its neighbours.
// The scanner (master) drives the keypad columns and the mallet outputs and
// reads the keypad rows; the slave side is the keypad plus the game core.
interface keypad_mallet_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] mallet_position;
  logic       PRESS_VALID;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n,
    output mallet_position,
    output PRESS_VALID,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  mallet_position,
    input  PRESS_VALID,
    input  key_held
  );
endinterface

// File: rtl/keypad_mallet_scanner.sv
// keypad_mallet_scanner: scans a 4x4 active-low matrix keypad one column at a
// time, debounces press and release of the first key found, and reports each
// accepted press as a one-cycle PRESS_VALID strobe with the key code
// {row_idx, col_idx} on mallet_position.
module keypad_mallet_scanner #(
  parameter int SCAN_PERIOD = 1000,
  parameter int DEBOUNCE    = 10000,
  parameter int CNT_W       = 20
) (
  input  logic                    clk_1us,
  input  logic                    reset,
  keypad_mallet_scanner_if.master bus
);

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_WAIT_REL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_PERIOD - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

  // Lowest row index whose (active-low) line is pulled down.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    lowest_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) lowest_low = 2'(i);
    end
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_col_idx;
  logic [1:0]       w_col_idx_nxt;
  logic [3:0]       r_col_n;
  logic [1:0]       r_cand_row;
  logic [1:0]       w_cand_row_nxt;
  logic [1:0]       r_cand_col;
  logic [1:0]       w_cand_col_nxt;
  logic [3:0]       r_pos;
  logic [3:0]       w_pos_nxt;
  logic             r_pv;
  logic             w_pv_nxt;
  logic             r_held;
  logic             w_held_nxt;
  logic [3:0]       r_row_p0;
  logic [3:0]       r_row_p1;
  logic [3:0]       w_row_s;
  logic             w_cand_bit;

  assign w_row_s    = r_row_p1;
  assign w_cand_bit = w_row_s[r_cand_row];

  // Two-flop synchroniser for the asynchronous row lines (idle = released).
  always_ff @(posedge clk_1us or posedge reset) begin
    if (reset) begin
      r_row_p0 <= 4'hF;
      r_row_p1 <= 4'hF;
    end else begin
      r_row_p0 <= bus.row_n;
      r_row_p1 <= r_row_p0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_1us or posedge reset) begin
    if (reset) begin
      r_state <= ST_SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, counter, column and mallet outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_col_idx_nxt  = r_col_idx;
    w_cand_row_nxt = r_cand_row;
    w_cand_col_nxt = r_cand_col;
    w_pos_nxt      = r_pos;
    w_pv_nxt       = 1'b0;
    w_held_nxt     = r_held;
    case (r_state)
      ST_SCAN: begin
        if (r_cnt == SCAN_LAST) begin
          w_cnt_nxt = '0;
          if (w_row_s != 4'hF) begin
            // Hold this column and start debouncing the lowest active row.
            w_cand_row_nxt = lowest_low(w_row_s);
            w_cand_col_nxt = r_col_idx;
            w_state_nxt    = ST_DEB_PRESS;
          end else begin
            w_col_idx_nxt = r_col_idx + 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_DEB_PRESS: begin
        if (w_cand_bit) begin
          // Bounce or abandoned press: rescan the same column, no strobe.
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SCAN;
        end else if (r_cnt == DEB_LAST) begin
          w_pv_nxt    = 1'b1;
          w_pos_nxt   = {r_cand_row, r_cand_col};
          w_held_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT_REL;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_WAIT_REL: begin
        if (!w_cand_bit) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_held_nxt    = 1'b0;
          w_cnt_nxt     = '0;
          w_col_idx_nxt = r_col_idx + 2'd1;
          w_state_nxt   = ST_SCAN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        // Unreachable encoding: restart scanning from column 0.
        w_state_nxt   = ST_SCAN;
        w_cnt_nxt     = '0;
        w_col_idx_nxt = 2'd0;
        w_pv_nxt      = 1'b0;
        w_held_nxt    = 1'b0;
      end
    endcase
  end

  // Counter, column, candidate and output registers.
  always_ff @(posedge clk_1us or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_col_idx  <= 2'd0;
      r_col_n    <= 4'b1110;
      r_cand_row <= 2'd0;
      r_cand_col <= 2'd0;
      r_pos      <= 4'd0;
      r_pv       <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_col_idx  <= w_col_idx_nxt;
      r_col_n    <= col_drive(w_col_idx_nxt);
      r_cand_row <= w_cand_row_nxt;
      r_cand_col <= w_cand_col_nxt;
      r_pos      <= w_pos_nxt;
      r_pv       <= w_pv_nxt;
      r_held     <= w_held_nxt;
    end
  end

  assign bus.col_n           = r_col_n;
  assign bus.mallet_position = r_pos;
  assign bus.PRESS_VALID     = r_pv;
  assign bus.key_held        = r_held;

endmodule

// File: tb/tb_keypad_mallet_scanner.sv
// Bench for keypad_mallet_scanner: a simulated 4x4 keypad drives the rows
// from the scanned columns, and a behavioural model of the scanner is
// compared with the DUT outputs on every cycle.
module tb_keypad_mallet_scanner;
  localparam int SP = 4;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_mallet_scanner_if u_if();

  keypad_mallet_scanner #(.SCAN_PERIOD(SP), .DEBOUNCE(DB), .CNT_W(8)) dut (
    .clk_1us (clk),
    .reset   (rst),
    .bus     (u_if.master)
  );

  // Physical keypad: keys[r*4+c] pressed connects row r to column c.
  bit keys [16];

  // Behavioural model: mode 0 scanning, 1 confirming a press, 2 awaiting release.
  int         m_mode, m_cnt, m_col, m_crow, m_ccol;
  logic [3:0] m_pos;
  logic       m_pv, m_held;
  logic [3:0] m_h1, m_h2;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         strobes = 0;
  logic [3:0] last_pos = 4'd0;
  int         cyc = 0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] keypad_rows(input logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (keys[ri*4+ci] && !cols[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  task automatic drive_rows();
    u_if.row_n = keypad_rows(u_if.col_n);
  endtask

  task automatic release_all();
    for (int k = 0; k < 16; k++) keys[k] = 1'b0;
    drive_rows();
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_col = 0; m_crow = 0; m_ccol = 0;
    m_pos = 4'd0; m_pv = 1'b0; m_held = 1'b0;
    m_h1 = 4'hF; m_h2 = 4'hF;
  endtask

  task automatic model_step();
    logic [3:0] rs;
    rs = m_h2;
    m_pv = 1'b0;
    case (m_mode)
      0: begin
        m_cnt++;
        if (m_cnt == SP) begin
          m_cnt = 0;
          if (rs != 4'hF) begin
            for (int i = 3; i >= 0; i--) if (!rs[i]) m_crow = i;
            m_ccol = m_col;
            m_mode = 1;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
      end
      1: begin
        if (rs[m_crow]) begin
          m_cnt = 0; m_mode = 0;
        end else begin
          m_cnt++;
          if (m_cnt == DB) begin
            m_pv = 1'b1; m_pos = 4'(m_crow * 4 + m_ccol); m_held = 1'b1;
            m_cnt = 0; m_mode = 2;
          end
        end
      end
      default: begin
        if (!rs[m_crow]) begin
          m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == DB) begin
            m_held = 1'b0; m_cnt = 0; m_col = (m_col + 1) % 4; m_mode = 0;
          end
        end
      end
    endcase
    m_h2 = m_h1;
    m_h1 = u_if.row_n;
  endtask

  // One clock: model advances at the edge, outputs compared at the falling edge.
  task automatic tick();
    logic [3:0] one;
    logic [3:0] exp_col;
    one = 4'b0001;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    cyc++;
    exp_col = ~(one << m_col);
    check("col_n", u_if.col_n, exp_col);
    check("mallet_position", u_if.mallet_position, m_pos);
    check("PRESS_VALID", {3'b0, u_if.PRESS_VALID}, {3'b0, m_pv});
    check("key_held", {3'b0, u_if.key_held}, {3'b0, m_held});
    if (u_if.PRESS_VALID === 1'b1) begin
      strobes++;
      last_pos = u_if.mallet_position;
    end
    drive_rows();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Tick until key_held equals val; an exhausted budget counts as a failure.
  task automatic wait_held(input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (u_if.key_held !== val && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (u_if.key_held !== val) begin
      n_fail++;
      $display("FAIL %s cyc=%0d key_held=%b expected=%b within %0d cycles", name, cyc, u_if.key_held, val, budget);
    end
  endtask

  // Called at a falling edge: assert reset, check outputs at once, release.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_col_n", u_if.col_n, 4'b1110);
    check("rst_pos", u_if.mallet_position, 4'd0);
    check("rst_pv", {3'b0, u_if.PRESS_VALID}, 4'd0);
    check("rst_held", {3'b0, u_if.key_held}, 4'd0);
    drive_rows();
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic set_key(input int r, input int c, input bit on);
    keys[r*4+c] = on;
    drive_rows();
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_col;
    int n;
    int k0, k1, two;
    one = 4'b0001;
    rst = 1'b1;
    for (int k = 0; k < 16; k++) keys[k] = 1'b0;
    u_if.row_n = 4'hF;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle: columns rotate every SP cycles, no strobe.
    strobes = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_col = ~(one << ((k / SP) % 4));
      check("idle_col_seq", u_if.col_n, exp_col);
    end
    check_int("idle_strobes", strobes, 0);

    // Clean press of row 2 / column 1, held.
    strobes = 0;
    set_key(2, 1, 1'b1);
    wait_held(1'b1, 200, "clean_press");
    check_int("clean_strobes", strobes, 1);
    check("clean_code", last_pos, 4'd9);
    for (int k = 0; k < 30; k++) begin
      tick();
      check("clean_col_held", u_if.col_n, 4'b1101);
    end
    check_int("clean_no_repeat", strobes, 1);
    release_all();
    wait_held(1'b0, 100, "clean_release");

    // Bouncing press of row 0 / column 3, then settles low.
    strobes = 0;
    for (int b = 0; b < 6; b++) begin
      set_key(0, 3, 1'b1); ticks(3);
      set_key(0, 3, 1'b0); ticks(1);
    end
    check_int("bounce_no_strobe", strobes, 0);
    set_key(0, 3, 1'b1);
    wait_held(1'b1, 200, "bounce_press");
    check_int("bounce_strobes", strobes, 1);
    check("bounce_code", last_pos, 4'd3);

    // Bouncing release: held stays high until the release is stable.
    for (int b = 0; b < 4; b++) begin
      set_key(0, 3, 1'b0); ticks(3);
      set_key(0, 3, 1'b1); ticks(1);
    end
    check("rel_bounce_held", {3'b0, u_if.key_held}, 4'd1);
    set_key(0, 3, 1'b0);
    wait_held(1'b0, 100, "rel_bounce_release");
    check("rel_next_col", u_if.col_n, 4'b1110);
    check_int("rel_no_second_strobe", strobes, 1);

    // Rows 1 and 3 together in column 0: lowest row wins.
    release_all();
    ticks(20);
    strobes = 0;
    set_key(1, 0, 1'b1);
    set_key(3, 0, 1'b1);
    wait_held(1'b1, 200, "multi_press");
    check("multi_code", last_pos, 4'd4);
    set_key(1, 0, 1'b0);
    n = 0;
    while (u_if.key_held === 1'b1 && n < 50) begin tick(); n++; end
    check_int("multi_release_latency", n, DB + 2);
    wait_held(1'b1, 200, "multi_repress");
    check("multi_second_code", last_pos, 4'd12);
    check_int("multi_strobes", strobes, 2);
    release_all();
    wait_held(1'b0, 100, "multi_release_all");
    ticks(10);

    // Reset while confirming a press at count 5.
    set_key(2, 0, 1'b1);
    n = 0;
    while (!(m_mode == 1 && m_cnt == 5) && n < 200) begin tick(); n++; end
    check_int("reach_deb_cnt5", (m_mode == 1 && m_cnt == 5) ? 1 : 0, 1);
    strobes = 0;
    do_reset();
    check_int("reset_no_strobe", strobes, 0);
    n = 0;
    while (strobes == 0 && n < 40) begin tick(); n++; end
    check_int("reset_fresh_debounce", n, 3 * 0 + SP + DB);
    check("reset_code", last_pos, 4'd8);
    release_all();
    wait_held(1'b0, 100, "reset_release");

    // Randomised presses with bounce, occasional resets.
    for (int it = 0; it < 30; it++) begin
      release_all();
      ticks($urandom_range(0, 20));
      k0 = $urandom_range(0, 15);
      two = $urandom_range(0, 2);
      k1 = $urandom_range(0, 15);
      for (int b = $urandom_range(0, 3); b > 0; b--) begin
        keys[k0] = 1'b1; if (two == 0) keys[k1] = 1'b1; drive_rows();
        ticks($urandom_range(1, 4));
        keys[k0] = 1'b0; drive_rows();
        ticks($urandom_range(1, 2));
      end
      keys[k0] = 1'b1; if (two == 0) keys[k1] = 1'b1; drive_rows();
      ticks($urandom_range(5, 60));
      if ($urandom_range(0, 7) == 0) do_reset();
      for (int b = $urandom_range(0, 3); b > 0; b--) begin
        release_all();
        ticks($urandom_range(1, 5));
        keys[k0] = 1'b1; drive_rows();
        ticks(1);
      end
      release_all();
      ticks($urandom_range(15, 40));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
